// File: rtl/seq_pkg.sv
// Shared definitions for the "01" pattern transmitter: FSM states, line levels
// and the reference "01"-pair counter over a framed word.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START0 = 3'd1,
        START1 = 3'd2,
        DATA   = 3'd3,
        STOP   = 3'd4
    } seq_state_e;

    localparam logic       IDLE_LVL  = 1'b1;
    // Start marker, sent MSB first: 0 then 1.
    localparam logic [1:0] START_PAT = 2'b01;
    localparam int         MAX_W     = 64;

    // Number of adjacent (0,1) pairs in {1, 0, 1, d[width-1:0], 1}.
    // The marker always contributes one hit. The stop bit contributes one when d[0] is 0.
    function automatic int count_01(input logic [MAX_W-1:0] d, input int width);
        int n;
        n = 1;
        for (int i = 1; i < MAX_W; i++) begin
            if (i < width && !d[i] && d[i-1])
                n++;
        end
        if (!d[0])
            n++;
        return n;
    endfunction

endpackage

// File: rtl/seq_hit_count.sv
// Combinational count of "01" pairs a detector will see for one framed word.
module seq_hit_count
    import seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 3)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt
);

    assign cnt = CNT_W'(count_01(MAX_W'(data), WIDTH));

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: 0,1 start marker, MSB-first data, 1 stop bit.
// It also reports the "01" hit count a downstream detector should flag for the frame.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 3)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             x,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int              BC_W     = $clog2(WIDTH);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]  bit_q, bit_d;
    logic [CNT_W-1:0] hit_d, hit_calc;
    logic             x_d, ready_d, busy_d, done_d;

    seq_hit_count #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_hit (
        .data (data),
        .cnt  (hit_calc)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        hit_d   = hit_cnt;
        unique case (state_q)
            IDLE: begin
                if (valid && ready) begin
                    state_d = START0;
                    shreg_d = data;
                    hit_d   = hit_calc;
                end
            end
            START0: state_d = START1;
            START1: begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: begin
                shreg_d = shreg_q << 1;
                if (bit_q == LAST_BIT)
                    state_d = STOP;
                else
                    bit_d = bit_q + 1'b1;
            end
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency to the line.
    always_comb begin
        x_d     = IDLE_LVL;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        unique case (state_d)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            START0:  x_d = START_PAT[1];
            START1:  x_d = START_PAT[0];
            DATA:    x_d = shreg_d[WIDTH-1];
            STOP:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_q      <= '0;
            hit_cnt    <= '0;
            x          <= IDLE_LVL;
            ready      <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_q      <= bit_d;
            hit_cnt    <= hit_d;
            x          <= x_d;
            ready      <= ready_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

endmodule
